// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer driving one mont_mult.
// Build option MOD_EXP_SKIP_LZ_EN: skip exponent leading zeros (default build scans all bits).
module mod_exp_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             me_start,
  input  logic [7:0]       len,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] r2,
  output logic             me_end,
  output logic [WIDTH-1:0] me_out,
  output logic             md_start,
  output logic [7:0]       mm_len,
  output logic [WIDTH-1:0] mm_num_1,
  output logic [WIDTH-1:0] mm_num_2,
  output logic [WIDTH-1:0] mm_modulus,
  input  logic             md_end,
  input  logic [WIDTH-1:0] mm_out
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [2:0] {OP_XBAR, OP_ONE, OP_SQR, OP_MUL, OP_POST} op_t;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_next;
  op_t              r_op, w_op_next;
  logic [5:0]       r_bit, w_bit_next;
  logic [WIDTH-1:0] r_base, r_exp, r_r2, r_acc, r_xbar;
  logic             r_e_zero, r_no_loop;
  logic             w_accept, w_capture, w_ebit;
  logic [WIDTH-1:0] w_exp_shift;
  logic [5:0]       w_bit_init;
  logic             w_e_zero_init, w_no_loop_init;

`ifdef MOD_EXP_SKIP_LZ_EN
  localparam logic SKIP_LZ = 1'b1;
  logic [5:0] w_msb;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < WIDTH; i++)
      if (exponent[i]) w_msb = 6'(i);
  end

  // The top set bit is absorbed by acc = xbar, so the loop begins one bit lower.
  assign w_e_zero_init  = (exponent == '0);
  assign w_no_loop_init = (w_msb == 6'd0);
  assign w_bit_init     = w_msb - 6'd1;
`else
  localparam logic SKIP_LZ = 1'b0;
  assign w_e_zero_init  = 1'b0;
  assign w_no_loop_init = 1'b0;
  assign w_bit_init     = 6'(WIDTH - 1);
`endif

  assign w_exp_shift = r_exp >> r_bit;
  assign w_ebit      = w_exp_shift[0];
  assign w_accept    = (r_state == S_IDLE) && me_start;
  assign w_capture   = (r_state == S_WAIT) && md_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_op    <= OP_XBAR;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_bit   <= w_bit_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_bit_next   = r_bit;
    md_start     = 1'b0;
    me_end       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (me_start) begin
          w_state_next = S_ISSUE;
          w_op_next    = OP_XBAR;
          w_bit_next   = w_bit_init;
        end
      end
      S_ISSUE: begin
        if (r_e_zero) begin
          w_state_next = S_DONE;
        end else begin
          md_start     = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (md_end) begin
          w_state_next = S_ISSUE;
          case (r_op)
            OP_XBAR: begin
              if (r_no_loop)    w_op_next = OP_POST;
              else if (SKIP_LZ) w_op_next = OP_SQR;
              else              w_op_next = OP_ONE;
            end
            OP_ONE: w_op_next = OP_SQR;
            OP_SQR: begin
              if (w_ebit) begin
                w_op_next = OP_MUL;
              end else if (r_bit == 6'd0) begin
                w_op_next = OP_POST;
              end else begin
                w_op_next  = OP_SQR;
                w_bit_next = r_bit - 6'd1;
              end
            end
            OP_MUL: begin
              if (r_bit == 6'd0) begin
                w_op_next = OP_POST;
              end else begin
                w_op_next  = OP_SQR;
                w_bit_next = r_bit - 6'd1;
              end
            end
            default: w_state_next = S_DONE;
          endcase
        end
      end
      default: begin
        me_end       = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mm_len     <= '0;
      mm_modulus <= '0;
      r_base     <= '0;
      r_exp      <= '0;
      r_r2       <= '0;
      r_acc      <= '0;
      r_xbar     <= '0;
      r_e_zero   <= 1'b0;
      r_no_loop  <= 1'b0;
      me_out     <= '0;
    end else begin
      if (w_accept) begin
        mm_len     <= len;
        mm_modulus <= modulus;
        r_base     <= base;
        r_exp      <= exponent;
        r_r2       <= r2;
        r_e_zero   <= w_e_zero_init;
        r_no_loop  <= w_no_loop_init;
      end
      if (r_state == S_ISSUE && r_e_zero)
        me_out <= ONE_W;
      if (w_capture) begin
        case (r_op)
          OP_XBAR: begin
            r_xbar <= mm_out;
            if (SKIP_LZ) r_acc <= mm_out;
          end
          OP_POST: me_out <= mm_out;
          default: r_acc <= mm_out;
        endcase
      end
    end
  end

  // Operands are a pure function of registers that only move on md_end, so they hold through WAIT.
  always_comb begin
    mm_num_1 = r_acc;
    mm_num_2 = r_acc;
    case (r_op)
      OP_XBAR: begin
        mm_num_1 = r_base;
        mm_num_2 = r_r2;
      end
      OP_ONE: begin
        mm_num_1 = r_r2;
        mm_num_2 = ONE_W;
      end
      OP_MUL:  mm_num_2 = r_xbar;
      OP_POST: mm_num_2 = ONE_W;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural Montgomery multiplier, directed vector table,
// plus mid-run restart, reset and back-to-back sequences.
module tb_mod_exp_ctrl;
  localparam int WIDTH = 32;

`ifdef MOD_EXP_SKIP_LZ_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             me_start = 1'b0;
  logic [7:0]       len = 8'd0;
  logic [WIDTH-1:0] base = '0;
  logic [WIDTH-1:0] exponent = '0;
  logic [WIDTH-1:0] modulus = '0;
  logic [WIDTH-1:0] r2 = '0;
  logic             me_end;
  logic [WIDTH-1:0] me_out;
  logic             md_start;
  logic [7:0]       mm_len;
  logic [WIDTH-1:0] mm_num_1;
  logic [WIDTH-1:0] mm_num_2;
  logic [WIDTH-1:0] mm_modulus;
  logic             md_end = 1'b0;
  logic [WIDTH-1:0] mm_out = '0;

  int n_tests = 0;
  int n_fail = 0;
  int n_pulses = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rstn(rstn), .me_start(me_start), .len(len), .base(base),
    .exponent(exponent), .modulus(modulus), .r2(r2), .me_end(me_end),
    .me_out(me_out), .md_start(md_start), .mm_len(mm_len), .mm_num_1(mm_num_1),
    .mm_num_2(mm_num_2), .mm_modulus(mm_modulus), .md_end(md_end), .mm_out(mm_out)
  );

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    logic [31:0] res;
    int          p_skip;
    int          p_full;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // a*b*2^-l mod n, bit-serial
  function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] n, input logic [7:0] l);
    logic [63:0] t;
    logic [31:0] aa;
    t  = '0;
    aa = a;
    for (int i = 0; i < int'(l); i++) begin
      if (aa[0]) t = t + {32'd0, b};
      if (t[0]) t = t + {32'd0, n};
      t  = t >> 1;
      aa = aa >> 1;
    end
    if (t >= {32'd0, n}) t = t - {32'd0, n};
    return t[31:0];
  endfunction

  task automatic mont_model();
    logic        busy = 1'b0;
    logic        chk_on = 1'b0;
    logic        prev = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] n = '0;
    logic [7:0]  l = '0;
    int          lat = 0;
    forever begin
      @(negedge clk);
      md_end = 1'b0;
      if (!rstn) chk_on = 1'b0;
      if (md_start) begin
        chk("md_start_width", 64'(prev), 64'd0);
        n_pulses++;
        busy   = 1'b1;
        chk_on = 1'b1;
        a = mm_num_1;
        b = mm_num_2;
        n = mm_modulus;
        l = mm_len;
        lat = int'($urandom_range(0, 3));
      end else if (busy) begin
        if (chk_on) chk("operand_hold", {mm_num_1, mm_num_2}, {a, b});
        if (lat == 0) begin
          md_end = 1'b1;
          mm_out = mont(a, b, n, l);
          busy   = 1'b0;
        end else begin
          lat--;
        end
      end
      prev = md_start;
    end
  endtask

  task automatic start_run(input logic [31:0] b, input logic [31:0] e);
    @(posedge clk); #1;
    base     = b;
    exponent = e;
    me_start = 1'b1;
    @(posedge clk); #1;
    me_start = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] res, output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    res = '0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (me_end) begin
        got = 1'b1;
        res = me_out;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got no me_end after %0d cycles, required me_end", cyc);
    end
  endtask

  function automatic int exp_pulses(input vec_t v);
    return SKIP ? v.p_skip : v.p_full;
  endfunction

  initial begin
    logic [31:0] res;
    logic [31:0] prev_res;
    int          cyc;

    fork
      mont_model();
    join_none

    vecs[0] = '{32'd5,  32'd3,          32'd8,  4,  37};
    vecs[1] = '{32'd7,  32'd65537,      32'd11, 19, 37};
    vecs[2] = '{32'd2,  32'd12,         32'd1,  6,  37};
    vecs[3] = '{32'd5,  32'd0,          32'd1,  0,  35};
    vecs[4] = '{32'd12, 32'd2,          32'd1,  3,  36};
    vecs[5] = '{32'd2,  32'hFFFF_FFFF,  32'd8,  64, 67};

    len     = 8'd4;
    modulus = 32'd13;
    r2      = 32'd9;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_me_end", 64'(me_end), 64'd0);
    chk("rst_md_start", 64'(md_start), 64'd0);
    chk("rst_me_out", 64'(me_out), 64'd0);
    chk("rst_mm_num", {mm_num_1, mm_num_2}, 64'd0);
    chk("rst_mm_modulus", 64'(mm_modulus), 64'd0);
    chk("rst_mm_len", 64'(mm_len), 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      n_pulses = 0;
      start_run(vecs[i].b, vecs[i].e);
      wait_done(res, cyc);
      $display("[TB] vec %0d base=%0d e=%0d me_out=%0d pulses=%0d cycles=%0d",
               i, vecs[i].b, vecs[i].e, res, n_pulses, cyc);
      chk("vec_result", 64'(res), 64'(vecs[i].res));
      chk("vec_pulses", 64'(n_pulses), 64'(exp_pulses(vecs[i])));
      if (SKIP && vecs[i].e == 32'd0) chk("e0_latency", 64'(cyc), 64'd2);
      @(negedge clk);
      chk("me_end_width", 64'(me_end), 64'd0);
      chk("me_out_hold", 64'(me_out), 64'(vecs[i].res));
    end

    // me_start while busy must not disturb the run in progress
    n_pulses = 0;
    start_run(32'd7, 32'd65537);
    repeat (15) @(posedge clk);
    #1;
    base     = 32'd5;
    exponent = 32'd3;
    me_start = 1'b1;
    @(posedge clk); #1;
    me_start = 1'b0;
    wait_done(res, cyc);
    $display("[TB] midrun_start me_out=%0d pulses=%0d", res, n_pulses);
    chk("midrun_result", 64'(res), 64'd11);
    chk("midrun_pulses", 64'(n_pulses), 64'(SKIP ? 19 : 37));

    // reset mid-run, then a restart
    start_run(32'd7, 32'd65537);
    repeat (20) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_me_end", 64'(me_end), 64'd0);
    chk("midrst_md_start", 64'(md_start), 64'd0);
    chk("midrst_me_out", 64'(me_out), 64'd0);
    chk("midrst_mm_num", {mm_num_1, mm_num_2}, 64'd0);
    chk("midrst_mm_modulus", 64'(mm_modulus), 64'd0);
    chk("midrst_mm_len", 64'(mm_len), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    n_pulses = 0;
    repeat (8) @(negedge clk);
    chk("post_rst_idle_pulses", 64'(n_pulses), 64'd0);
    chk("post_rst_idle_me_end", 64'(me_end), 64'd0);
    n_pulses = 0;
    start_run(32'd5, 32'd3);
    wait_done(res, cyc);
    $display("[TB] restart me_out=%0d pulses=%0d", res, n_pulses);
    chk("restart_result", 64'(res), 64'd8);
    chk("restart_pulses", 64'(n_pulses), 64'(SKIP ? 4 : 37));

    // back-to-back: new me_start in the cycle right after me_end
    n_pulses = 0;
    start_run(32'd2, 32'd12);
    wait_done(prev_res, cyc);
    chk("b2b_first", 64'(prev_res), 64'd1);
    start_run(32'd7, 32'd65537);
    @(negedge clk);
    chk("b2b_me_out_hold", 64'(me_out), 64'(prev_res));
    wait_done(res, cyc);
    $display("[TB] back_to_back first=%0d second=%0d pulses=%0d", prev_res, res, n_pulses);
    chk("b2b_second", 64'(res), 64'd11);
    chk("b2b_pulses", 64'(n_pulses), 64'(SKIP ? 25 : 74));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
